uart_buffered: RTL and testbench
================================

UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 Parameter CLK_DIV, default 2604, clocks per bit; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter FIFO_DEPTH, default 8, entries per FIFO; power of 2, 2..256.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 RX  input  1  serial in, asynchronous to clk.
REQ-008 TX  output  1  serial out, registered.
REQ-009 tx_wr  input  1  push tx_data into the TX FIFO.
REQ-010 tx_data  input  DATA_BITS  byte to transmit.
REQ-011 tx_full  output  1  TX FIFO full.
REQ-012 tx_busy  output  1  shifter active or TX FIFO not empty.
REQ-013 rx_rd  input  1  pop the RX FIFO head.
REQ-014 rx_data  output  DATA_BITS  RX FIFO head, first-word fall-through.
REQ-015 rx_empty  output  1  RX FIFO empty.
REQ-016 rx_count  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
REQ-017 err  output  3  sticky {overrun, frame, parity}.
REQ-018 clr_err  input  1  clears all err bits.

Function
REQ-019 Frame format: one start bit (0), DATA_BITS data bits LSB first, one parity bit if PARITY!=0, one stop bit (1); each bit lasts exactly CLK_DIV clocks.
REQ-020 tx_wr while tx_full is ignored, with no FIFO change; tx_wr while not full writes tx_data, and tx_full updates in the same cycle.
REQ-021 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE with FIFO non-empty pops the head and enters START on the next clock.
REQ-022 After STOP, the TX FSM returns to IDLE for 1 clock; with a non-empty FIFO, back-to-back frames have a 1-clock idle gap on TX.
REQ-023 Parity bit: XOR of the data bits (even), or its inverse (odd).
REQ-024 RX passes through a 2-flop synchroniser; a falling edge in IDLE starts a bit counter.
REQ-025 Start bit is re-sampled at CLK_DIV/2; if high, it is a false start: return to IDLE, no push, no error.
REQ-026 Data, parity and stop bits are sampled at CLK_DIV/2 into each bit period.
REQ-027 Stop bit sampled 0: byte discarded, err[1] set, RX FSM waits for RX high before re-arming.
REQ-028 Parity mismatch: byte is still pushed and err[0] is set.
REQ-029 Push with RX FIFO full and no rx_rd in the same cycle: byte dropped, err[2] set, FIFO contents unchanged.
REQ-030 Push and rx_rd in the same cycle on a full FIFO: both succeed, rx_count stays at FIFO_DEPTH, no overrun.
REQ-031 rx_rd while rx_empty is ignored.
REQ-032 rx_data is undefined-but-stable while empty; it updates 1 clock after a push into an empty FIFO.
REQ-033 err bits stay set until clr_err; clr_err coinciding with a new error leaves that bit set.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with one extra bit to separate full from empty.

Reset
REQ-035 While rst_n is low: TX=1, tx_full=0, tx_busy=0, rx_empty=1, rx_count=0, err=0, both FSMs IDLE, both FIFOs emptied, synchroniser flops =1.
REQ-036 Reset mid-frame aborts the frame immediately; TX goes high the same edge.
REQ-037 A partially received byte is lost on reset.

Verification (CLK_DIV=16, DATA_BITS=8, PARITY=1, FIFO_DEPTH=4, TX looped to RX)
REQ-038 Single byte: write 0xA5 -> TX low for 16 clocks, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> 176 clocks total; rx_count=1, rx_data=0xA5, err=0.
REQ-039 Back-to-back: write 0x00,0xFF,0x55,0xAA with no reads -> all four received in order, rx_count=4, tx_busy falls after the last stop bit; a fifth frame -> err=3'b100, head still 0x00.
REQ-040 Full-boundary: rx_count=4, rx_rd asserted exactly on the push cycle -> rx_count stays 4, err=0, new byte at the tail.
REQ-041 Bad frame via direct RX drive: stop bit=0 -> err=3'b010, rx_count unchanged; flipped parity on 0x3C -> 0x3C pushed, err=3'b001; clr_err -> err=0.
REQ-042 Glitch: RX low for 6 clocks -> no push, no error; then a reset pulse mid-transmit of 0x81 -> TX=1 the same edge, tx_busy=0, rx_empty=1.

Source files
------------

// File: rtl/uart_buffered.sv
// Buffered UART: TX and RX FIFOs around a frame shifter and a mid-bit sampling receiver.
// Frames are start, DATA_BITS LSB first, optional parity, one stop bit, CLK_DIV clocks per bit.
module uart_buffered #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX,
  output logic                        TX,
  input  logic                        tx_wr,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_full,
  output logic                        tx_busy,
  input  logic                        rx_rd,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_empty,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic [2:0]                  err,
  input  logic                        clr_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic          PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp_q, tx_rp_q;
  logic                 tx_empty, tx_push, tx_pop;
  tx_state_t            tx_state_q;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_push  = tx_wr && !tx_full;
  assign tx_pop   = (tx_state_q == T_IDLE) && !tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
    end
  end

  // ---------------- TX shifter ----------------
  logic [CW-1:0]        tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q, tx_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          if (!tx_empty) begin
            tx_shift_q <= tx_mem[tx_rp_q[AW-1:0]];
            tx_par_q   <= (^tx_mem[tx_rp_q[AW-1:0]]) ^ PAR_ODD;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= T_START;
          end
        end
        default: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            case (tx_state_q)
              T_START: begin
                tx_q       <= tx_shift_q[0];
                tx_state_q <= T_DATA;
              end
              T_DATA: begin
                if (tx_bit_q == LAST_BIT) begin
                  tx_q       <= (PARITY != 0) ? tx_par_q : 1'b1;
                  tx_state_q <= (PARITY != 0) ? T_PARITY : T_STOP;
                end else begin
                  tx_bit_q   <= tx_bit_q + BW'(1);
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_q       <= tx_shift_q[1];
                end
              end
              T_PARITY: begin
                tx_q       <= 1'b1;
                tx_state_q <= T_STOP;
              end
              default: tx_state_q <= T_IDLE;
            endcase
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign TX      = tx_q;
  assign tx_busy = (tx_state_q != T_IDLE) || !tx_empty;

  // ---------------- RX synchroniser and receiver ----------------
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q, rx_s;
  rx_state_t            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_done, rx_push, rx_ferr, rx_perr;

  assign rx_s    = rx_sync2_q;
  assign rx_done = (rx_cnt_q == BIT_END);
  assign rx_push = (rx_state_q == R_STOP) && rx_done && rx_s;
  assign rx_ferr = (rx_state_q == R_STOP) && rx_done && !rx_s;
  assign rx_perr = (rx_state_q == R_PARITY) && rx_done && (rx_s != ((^rx_shift_q) ^ PAR_ODD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  // The start bit is checked at half a bit, then every later sample is one full bit apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_done) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= (PARITY != 0) ? R_PARITY : R_STOP;
            else                      rx_bit_q   <= rx_bit_q + BW'(1);
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_PARITY: begin
          if (rx_done) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_done) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s ? R_IDLE : R_WAIT;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: if (rx_s) rx_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp_q, rx_rp_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic [AW-1:0]        rx_rp_nxt;
  logic                 rx_full, rx_pop, rx_wr, rx_ovr;
  logic [2:0]           err_q, err_d;

  assign rx_count  = rx_wp_q - rx_rp_q;
  assign rx_empty  = (rx_wp_q == rx_rp_q);
  assign rx_full   = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_pop    = rx_rd && !rx_empty;
  assign rx_wr     = rx_push && (!rx_full || rx_pop);
  assign rx_ovr    = rx_push && rx_full && !rx_pop;
  assign rx_rp_nxt = rx_rp_q[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_data_q <= '0;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + PTR_ONE;
      if (rx_pop) rx_rp_q <= rx_rp_q + PTR_ONE;
      // Head register tracks whichever entry will be at the read pointer after this edge.
      if (rx_pop) begin
        if (rx_count > PTR_ONE) rx_data_q <= rx_mem[rx_rp_nxt];
        else if (rx_wr)         rx_data_q <= rx_shift_q;
      end else if (rx_empty && rx_wr) begin
        rx_data_q <= rx_shift_q;
      end
    end
  end

  assign rx_data = rx_data_q;

  assign err_d = (clr_err ? 3'b000 : err_q) | {rx_ovr, rx_ferr, rx_perr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err = err_q;
endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered with TX looped back to RX; a read monitor scores popped bytes
// against a queue of expected bytes filled by the stimulus.
`timescale 1ns/1ps
module tb_uart_buffered;
  localparam int CLK_DIV    = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int CNTW       = $clog2(FIFO_DEPTH) + 1;
  // Edge where TX falls to edge where the receiver pushes: 2 sync flops + edge detect,
  // half a start bit, then 8 data + parity + stop bit periods.
  localparam int PUSH_LAT   = 3 + CLK_DIV/2 + 10*CLK_DIV;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tx_wr = 1'b0, rx_rd = 1'b0, clr_err = 1'b0;
  logic loop_en = 1'b1, rx_drv = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic TX, RX, tx_full, tx_busy, rx_empty;
  logic [7:0] rx_data;
  logic [CNTW-1:0] rx_count;
  logic [2:0] err;

  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];

  assign RX = loop_en ? TX : rx_drv;
  always #5 clk = ~clk;

  uart_buffered #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .err(err), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Read monitor: every accepted pop is scored against the next expected byte.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n && rx_rd && !rx_empty) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_read: got 0x%02h, expected no byte", rx_data);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] rx read 0x%02h (expected 0x%02h)", rx_data, e);
        check("rx_read", {24'h0, rx_data}, {24'h0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] b, input bit expect_rx);
    $display("[TB] tx write 0x%02h", b);
    tx_wr = 1'b1;
    tx_data = b;
    tick(1);
    tx_wr = 1'b0;
    if (expect_rx) exp_q.push_back(b);
  endtask

  task automatic rx_read();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, tx_busy}, 32'h0);
  endtask

  task automatic wait_tx_low(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (TX && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, TX}, 32'h0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop);
    $display("[TB] rx drive 0x%02h parity_flip=%0d stop=%0d", b, flip_par, stop);
    rx_drv = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(CLK_DIV);
    end
    rx_drv = (^b) ^ flip_par;
    tick(CLK_DIV);
    rx_drv = stop;
    tick(CLK_DIV);
    rx_drv = 1'b1;
    tick(4);
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin : stim
    logic [10:0] frame;
    logic        bad;
    logic        busy_last;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_tx", {31'h0, TX}, 32'h1);
    check("rst_tx_full", {31'h0, tx_full}, 32'h0);
    check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    check("rst_rx_empty", {31'h0, rx_empty}, 32'h1);
    check("rst_rx_count", {29'h0, rx_count}, 32'h0);
    check("rst_err", {29'h0, err}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, even parity 0, stop
    frame = 11'b1_0_10100101_0;
    tx_write(8'hA5, 1'b1);
    wait_tx_low("t1_start_seen");
    busy_last = 1'b0;
    for (int k = 0; k < 11; k++) begin
      bad = 1'b0;
      for (int j = 0; j < CLK_DIV; j++) begin
        if (TX !== frame[k]) bad = 1'b1;
        busy_last = tx_busy;
        @(negedge clk);
      end
      check($sformatf("t1_bit%0d_mismatch", k), {31'h0, bad}, 32'h0);
    end
    check("t1_busy_in_stop", {31'h0, busy_last}, 32'h1);
    check("t1_busy_after_176", {31'h0, tx_busy}, 32'h0);
    check("t1_tx_idle", {31'h0, TX}, 32'h1);
    check("t1_rx_count", {29'h0, rx_count}, 32'h1);
    check("t1_rx_data", {24'h0, rx_data}, 32'hA5);
    check("t1_err", {29'h0, err}, 32'h0);
    tick(1);
    rx_read();
    @(negedge clk);
    check("t1_rx_empty", {31'h0, rx_empty}, 32'h1);
    tick(1);

    // Back-to-back frames, no reads
    tx_write(8'h00, 1'b1);
    tx_write(8'hFF, 1'b1);
    tx_write(8'h55, 1'b1);
    tx_write(8'hAA, 1'b1);
    wait_idle("t2_busy_timeout", 3000);
    check("t2_rx_count", {29'h0, rx_count}, 32'h4);
    check("t2_err", {29'h0, err}, 32'h0);
    tick(1);
    tx_write(8'h12, 1'b0);
    wait_idle("t2_fifth_timeout", 1000);
    check("t2_overrun_err", {29'h0, err}, 32'h4);
    check("t2_count_after_ovr", {29'h0, rx_count}, 32'h4);
    check("t2_head", {24'h0, rx_data}, 32'h00);
    tick(1);
    clear_err();
    @(negedge clk);
    check("t2_err_cleared", {29'h0, err}, 32'h0);
    tick(1);

    // Full boundary: read exactly on the push edge
    tx_write(8'h69, 1'b1);
    wait_tx_low("t3_start_seen");
    repeat (PUSH_LAT - 1) @(posedge clk);
    #1;
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    @(negedge clk);
    check("t3_rx_count", {29'h0, rx_count}, 32'h4);
    check("t3_err", {29'h0, err}, 32'h0);
    wait_idle("t3_busy_timeout", 1000);
    tick(1);
    for (int i = 0; i < 4; i++) rx_read();
    @(negedge clk);
    check("t3_drained", {31'h0, rx_empty}, 32'h1);
    tick(1);

    // Direct RX drive: bad stop, then flipped parity
    rx_drv = 1'b1;
    loop_en = 1'b0;
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_frame_err", {29'h0, err}, 32'h2);
    check("t4_count_unchanged", {29'h0, rx_count}, 32'h0);
    tick(1);
    clear_err();
    @(negedge clk);
    check("t4_err_cleared1", {29'h0, err}, 32'h0);
    tick(1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_parity_err", {29'h0, err}, 32'h1);
    check("t4_parity_count", {29'h0, rx_count}, 32'h1);
    check("t4_parity_data", {24'h0, rx_data}, 32'h3C);
    tick(1);
    rx_read();
    clear_err();
    @(negedge clk);
    check("t4_err_cleared2", {29'h0, err}, 32'h0);
    tick(1);

    // Glitch on RX: false start
    rx_drv = 1'b0;
    tick(6);
    rx_drv = 1'b1;
    tick(30);
    @(negedge clk);
    check("t5_glitch_empty", {31'h0, rx_empty}, 32'h1);
    check("t5_glitch_err", {29'h0, err}, 32'h0);
    tick(1);

    // Reset in the middle of transmitting 0x81
    loop_en = 1'b1;
    tx_write(8'h81, 1'b0);
    tick(49);
    @(negedge clk);
    check("t5_tx_low_before_rst", {31'h0, TX}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", {31'h0, TX}, 32'h1);
    check("t5_rst_busy", {31'h0, tx_busy}, 32'h0);
    check("t5_rst_rx_empty", {31'h0, rx_empty}, 32'h1);
    check("t5_rst_err", {29'h0, err}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(300);
    @(negedge clk);
    check("t5_post_rst_empty", {31'h0, rx_empty}, 32'h1);
    check("t5_post_rst_busy", {31'h0, tx_busy}, 32'h0);
    check("t5_post_rst_err", {29'h0, err}, 32'h0);

    check("pending_expected", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
